regfile_mp: RTL

- Parametrised multi-port integer register file; next generation of the ID/WB register file in the pipelined core.
- Width, depth, read-port count and debug tap are configurable.
- Adds a second write port (for a dual-writeback pipeline), a per-register pending scoreboard for stall generation, and a hardware clear engine that zeroes the array after reset or on request.
- Reads are combinational with WB bypass; writes are synchronous.

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, combinational reads with
// WB bypass, per-register pending scoreboard and a sequential clear engine.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int DBG_IDX  = 1
) (
    input  logic                     dclk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        re_i,
    input  logic [NUM_RD*AW-1:0]     raddr_i,
    output logic [NUM_RD*XLEN-1:0]   rdata_o,
    output logic [NUM_RD-1:0]        rpend_o,
    input  logic                     we0_i,
    input  logic [AW-1:0]            waddr0_i,
    input  logic [XLEN-1:0]          wdata0_i,
    input  logic                     we1_i,
    input  logic [AW-1:0]            waddr1_i,
    input  logic [XLEN-1:0]          wdata1_i,
    input  logic                     iss_i,
    input  logic [AW-1:0]            iss_addr_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic [XLEN-1:0]          dbg_o
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   dbg_q, dbg_d;
    logic [XLEN-1:0]   regs_q [DEPTH];

    logic idle;
    logic wr0_en, wr1_en, iss_en;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign idle       = (state_q == S_IDLE);
    assign wr0_en     = idle && we0_i && !is_zero_reg(waddr0_i);
    assign wr1_en     = idle && we1_i && !is_zero_reg(waddr1_i);
    assign iss_en     = idle && iss_i && !is_zero_reg(iss_addr_i);
    assign clr_busy_o = !idle;
    assign dbg_o      = dbg_q;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // An issue in the same cycle as a write to that register is the newer producer, so set wins.
    always_comb begin
        pend_d = pend_q;
        if (!idle) begin
            pend_d = '0;
        end else begin
            if (wr0_en) pend_d[waddr0_i] = 1'b0;
            if (wr1_en) pend_d[waddr1_i] = 1'b0;
            if (iss_en) pend_d[iss_addr_i] = 1'b1;
        end
    end

    always_comb begin
        dbg_d = regs_q[DBG_IDX];
        if (!idle) begin
            if (cnt_q == AW'(DBG_IDX)) dbg_d = '0;
        end else begin
            if (wr0_en && waddr0_i == AW'(DBG_IDX)) dbg_d = wdata0_i;
            if (wr1_en && waddr1_i == AW'(DBG_IDX)) dbg_d = wdata1_i;
        end
    end

    always_comb begin
        logic [AW-1:0]   addr;
        logic            hit0, hit1;
        logic [XLEN-1:0] data;
        rdata_o = '0;
        rpend_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = raddr_i[k*AW +: AW];
            hit0 = we0_i && (waddr0_i == addr);
            hit1 = we1_i && (waddr1_i == addr);
            data = '0;
            if (idle && re_i[k] && !is_zero_reg(addr)) begin
                if (hit1)      data = wdata1_i;
                else if (hit0) data = wdata0_i;
                else           data = regs_q[addr];
            end
            rdata_o[k*XLEN +: XLEN] = data;
            rpend_o[k] = idle && re_i[k] && pend_q[addr] && !hit0 && !hit1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dbg_q   <= dbg_d;
        end
    end

    // NOTE: the array has no reset; the clear engine zeroes it after every reset instead.
    always_ff @(posedge dclk) begin
        if (!idle) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (wr0_en) regs_q[waddr0_i] <= wdata0_i;
            if (wr1_en) regs_q[waddr1_i] <= wdata1_i;
        end
    end

endmodule
